uart_fifo_ctrl: RTL and testbench
=================================

# uart_fifo_ctrl

Buffered controller that sits between a host-side byte interface and a single `uart` core instance. It queues host bytes in a TX FIFO and sequences them into the core one frame at a time using the core's `transmit`/`is_transmitting` handshake. It drains the core's `received`/`recv_error` flags into an RX FIFO plus error counters, acknowledging every event with `recv_ack`.

## Interface
- `DEPTH`, 16: entries per FIFO. Must be a power of two, ≥2.
- `AW`, 4: log2(DEPTH). Count outputs are AW+1 bits.

Ports:
- `clk`  in  1  system clock, shared with the uart core.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  host push into the TX FIFO.
- `wr_data`  in  8  byte to push.
- `tx_full`  out  1  TX FIFO holds DEPTH entries.
- `tx_count`  out  AW+1  TX FIFO occupancy.
- `rd_en`  in  1  host pop from the RX FIFO.
- `rd_data`  out  8  RX FIFO head (show-ahead); valid when `rx_empty`=0.
- `rx_empty`  out  1  RX FIFO holds 0 entries.
- `rx_count`  out  AW+1  RX FIFO occupancy.
- `rx_overflow`  out  1  sticky: a received byte was dropped because the RX FIFO was full.
- `err_count`  out  8  saturating count of `recv_error` events.
- `stat_clr`  in  1  clears `rx_overflow` and `err_count`.
- `uart_transmit`  out  1  to core `transmit`.
- `uart_tx_byte`  out  8  to core `tx_byte`.
- `uart_is_transmitting`  in  1  from core.
- `uart_received`  in  1  from core.
- `uart_rx_byte`  in  8  from core.
- `uart_recv_error`  in  1  from core.
- `uart_recv_ack`  out  1  to core `recv_ack`.

## Operation
- Reset values: all FIFO pointers and counts 0; `tx_full`=0; `rx_empty`=1; `rx_overflow`=0; `err_count`=0; `uart_transmit`=0; `uart_tx_byte`=0; `uart_recv_ack`=0; both FSMs in IDLE.
- TX FIFO:
  - `wr_en` with `tx_full`=0 writes `wr_data`.
  - `wr_en` with `tx_full`=1 is dropped silently. Fullness is evaluated from the start-of-cycle count, so a same-cycle pop does not admit the write.
- TX FSM (registered outputs):
  - IDLE: if the FIFO is non-empty and `uart_is_transmitting`=0, load `uart_tx_byte` ← head, set `uart_transmit`=1, pop the head, and go to ISSUE.
  - ISSUE: `uart_transmit` returns to 0. Go to WAIT_BUSY.
  - WAIT_BUSY: on `uart_is_transmitting`=1, go to WAIT_DONE.
  - WAIT_DONE: on `uart_is_transmitting`=0, go to IDLE.
  - `uart_is_transmitting` is high after core reset (stop-bit delay). IDLE therefore naturally holds off the first frame.
  - `uart_transmit` is never high for more than one consecutive cycle.
  - `uart_tx_byte` holds its value until the next issue.
- RX FSM:
  - IDLE, on `uart_received`=1: push `uart_rx_byte` if the RX FIFO is not full; otherwise set `rx_overflow`. Drive `uart_recv_ack`=1 next cycle and go to ACK.
  - IDLE, on `uart_recv_error`=1: increment `err_count`, saturating at 255. Drive ack and go to ACK.
  - IDLE, both flags high in the same cycle: do both actions and a single ack.
  - ACK: `uart_recv_ack`=1 for exactly one cycle; the core clears its flags at this edge. Go to WAIT, ignoring core flags in this cycle.
  - WAIT: one cycle with ack low, then IDLE. The extra cycle guarantees the cleared flags are not re-sampled.
- RX FIFO:
  - `rd_en` with `rx_empty`=1 is ignored.
  - A simultaneous push and pop leaves the count unchanged, both take effect, and it is legal even when full. Overflow is judged on the start-of-cycle count minus a same-cycle pop.
- Pointers are AW bits and wrap modulo DEPTH. Counts are AW+1 bits, range 0..DEPTH.
- `stat_clr`: clears `rx_overflow` and `err_count` at that edge. If a new event arrives in the same cycle, the event wins: overflow=1, or `err_count`=1.
- Asynchronous reset mid-frame drops all queued data and returns both FSMs to IDLE. Resetting the core is the parent's duty.

## Timing
- Host write to `uart_transmit` high, with an idle core and empty FIFO: 2 cycles (write edge, then IDLE issue edge).
- Back-to-back frames: the next issue occurs no earlier than 1 cycle after `uart_is_transmitting` falls.
- `uart_received` rise to `rd_data` valid / `rx_empty`=0: 1 cycle. `uart_recv_ack` is high in cycle +1 only.
- RX event service interval is 3 cycles (IDLE, ACK, WAIT). This is far below one UART frame.
- `tx_full`, `rx_empty` and both counts are registered and reflect the state after the last edge.

## Test plan
- Reset, then push 0x55, 0xA3, with the core model holding busy 40 cycles per frame → `uart_tx_byte` = 0x55 then 0xA3, each issued with a single-cycle `uart_transmit`, with no issue while busy.
- Push 17 bytes with DEPTH=16 while the core is busy → `tx_full`=1, `tx_count`=16, 17th byte dropped; after drain exactly 16 frames are issued, in order.
- Core model raises `uart_received` with 0x3C and holds it until ack → one `uart_recv_ack` pulse at +1, `rd_data`=0x3C, `rx_count`=1; `rd_en` → `rx_empty`=1.
- Fill the RX FIFO to 16, deliver 0x77 → `rx_overflow`=1, count stays 16, ack still pulsed. Then `rd_en` and a delivery in the same cycle → count stays 16, no new overflow.
- `uart_recv_error` 300 times → `err_count`=255. Then `stat_clr` → 0, and `rx_overflow`=0.
- Assert `rst` during WAIT_DONE with 5 bytes queued → all outputs at their reset values immediately (asynchronously), `tx_count`=0, and no `uart_transmit` after release until a new write.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// Buffered host-side controller for a single uart core: TX FIFO feeding the core one frame at a
// time, RX FIFO plus error/overflow status draining the core's receive flags.
module uart_fifo_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // Host TX side
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  output logic          tx_full_o,
  output logic [AW:0]   tx_count_o,
  // Host RX side
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          rx_empty_o,
  output logic [AW:0]   rx_count_o,
  output logic          rx_overflow_o,
  output logic [7:0]    err_count_o,
  input  logic          stat_clr_i,
  // uart core side
  output logic          uart_transmit_o,
  output logic [7:0]    uart_tx_byte_o,
  input  logic          uart_is_transmitting_i,
  input  logic          uart_received_i,
  input  logic [7:0]    uart_rx_byte_i,
  input  logic          uart_recv_error_i,
  output logic          uart_recv_ack_o
);

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {TxIdle, TxIssue, TxWaitBusy, TxWaitDone} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxAck, RxWait} rx_state_e;

  // ---------------------------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------------------------
  logic [7:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [AW:0]   tx_cnt_q;
  logic          tx_full, tx_push, tx_pop;
  tx_state_e     tx_state_q;
  logic          tx_transmit_q;
  logic [7:0]    tx_byte_q;

  assign tx_full = (tx_cnt_q == FullCnt);
  // Fullness uses the start-of-cycle count, so a same-cycle pop never admits a write.
  assign tx_push = wr_en_i && !tx_full;
  assign tx_pop  = (tx_state_q == TxIdle) && (tx_cnt_q != '0) && !uart_is_transmitting_i;

  always_ff @(posedge clk_i) begin
    if (tx_push) begin
      tx_mem_q[tx_wptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // TX sequencer
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state_q    <= TxIdle;
      tx_transmit_q <= 1'b0;
      tx_byte_q     <= 8'h00;
    end else begin
      case (tx_state_q)
        TxIdle: begin
          if (tx_pop) begin
            tx_byte_q     <= tx_mem_q[tx_rptr_q];
            tx_transmit_q <= 1'b1;
            tx_state_q    <= TxIssue;
          end
        end
        TxIssue: begin
          tx_transmit_q <= 1'b0;
          tx_state_q    <= TxWaitBusy;
        end
        TxWaitBusy: begin
          if (uart_is_transmitting_i) tx_state_q <= TxWaitDone;
        end
        TxWaitDone: begin
          if (!uart_is_transmitting_i) tx_state_q <= TxIdle;
        end
        default: begin
          tx_transmit_q <= 1'b0;
          tx_state_q    <= TxIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // RX FIFO and status
  // ---------------------------------------------------------------------------------------------
  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [AW:0]   rx_cnt_q;
  rx_state_e     rx_state_q;
  logic          rx_ack_q;
  logic          rx_ovf_q;
  logic [7:0]    err_cnt_q;
  logic          rx_full, rx_pop, rx_push, rx_sample, ovf_set, err_inc;

  assign rx_full   = (rx_cnt_q == FullCnt);
  assign rx_pop    = rd_en_i && (rx_cnt_q != '0);
  assign rx_sample = (rx_state_q == RxIdle);
  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign rx_push   = rx_sample && uart_received_i && (!rx_full || rx_pop);
  assign ovf_set   = rx_sample && uart_received_i && rx_full && !rx_pop;
  assign err_inc   = rx_sample && uart_recv_error_i;

  always_ff @(posedge clk_i) begin
    if (rx_push) begin
      rx_mem_q[rx_wptr_q] <= uart_rx_byte_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end

  // New events take priority over a same-cycle status clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_ovf_q  <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      if (ovf_set) begin
        rx_ovf_q <= 1'b1;
      end else if (stat_clr_i) begin
        rx_ovf_q <= 1'b0;
      end
      if (err_inc) begin
        if (stat_clr_i) begin
          err_cnt_q <= 8'd1;
        end else if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end else if (stat_clr_i) begin
        err_cnt_q <= 8'h00;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // RX event sequencer: IDLE samples flags, ACK pulses recv_ack, WAIT skips the clearing edge
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_state_q <= RxIdle;
      rx_ack_q   <= 1'b0;
    end else begin
      case (rx_state_q)
        RxIdle: begin
          if (uart_received_i || uart_recv_error_i) begin
            rx_ack_q   <= 1'b1;
            rx_state_q <= RxAck;
          end
        end
        RxAck: begin
          rx_ack_q   <= 1'b0;
          rx_state_q <= RxWait;
        end
        RxWait: begin
          rx_state_q <= RxIdle;
        end
        default: begin
          rx_ack_q   <= 1'b0;
          rx_state_q <= RxIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign tx_full_o       = tx_full;
  assign tx_count_o      = tx_cnt_q;
  assign rd_data_o       = rx_mem_q[rx_rptr_q];
  assign rx_empty_o      = (rx_cnt_q == '0);
  assign rx_count_o      = rx_cnt_q;
  assign rx_overflow_o   = rx_ovf_q;
  assign err_count_o     = err_cnt_q;
  assign uart_transmit_o = tx_transmit_q;
  assign uart_tx_byte_o  = tx_byte_q;
  assign uart_recv_ack_o = rx_ack_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: behavioural uart core model, table-driven RX vectors,
// directed corner cases and a randomized phase against a queue-based reference model.
module tb_uart_fifo_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx_full;
  logic [AW:0]   tx_count;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rx_empty;
  logic [AW:0]   rx_count;
  logic          rx_overflow;
  logic [7:0]    err_count;
  logic          stat_clr = 1'b0;
  logic          uart_transmit;
  logic [7:0]    uart_tx_byte;
  logic          is_tx;
  logic          uart_received = 1'b0;
  logic [7:0]    uart_rx_byte = 8'h00;
  logic          uart_recv_error = 1'b0;
  logic          uart_recv_ack;

  uart_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .wr_en_i                (wr_en),
    .wr_data_i              (wr_data),
    .tx_full_o              (tx_full),
    .tx_count_o             (tx_count),
    .rd_en_i                (rd_en),
    .rd_data_o              (rd_data),
    .rx_empty_o             (rx_empty),
    .rx_count_o             (rx_count),
    .rx_overflow_o          (rx_overflow),
    .err_count_o            (err_count),
    .stat_clr_i             (stat_clr),
    .uart_transmit_o        (uart_transmit),
    .uart_tx_byte_o         (uart_tx_byte),
    .uart_is_transmitting_i (is_tx),
    .uart_received_i        (uart_received),
    .uart_rx_byte_i         (uart_rx_byte),
    .uart_recv_error_i      (uart_recv_error),
    .uart_recv_ack_o        (uart_recv_ack)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else n_pass++;
  endtask

  // Behavioural uart core TX side: busy for frame_len cycles after each accepted transmit.
  int        frame_len = 40;
  logic      hold_busy = 1'b1;
  int        busy_cnt  = 0;
  logic      prev_tx   = 1'b0;
  int        viol      = 0;
  logic [7:0] seen_q[$];

  assign is_tx = (busy_cnt != 0) || hold_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= 0;
      prev_tx  <= 1'b0;
    end else begin
      prev_tx <= uart_transmit;
      if (uart_transmit) begin
        if (prev_tx || is_tx) viol = viol + 1;
        seen_q.push_back(uart_tx_byte);
        busy_cnt <= frame_len;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic host_read();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    stat_clr = 1'b1;
    tick(1);
    stat_clr = 1'b0;
  endtask

  // Core raises its flags, holds them until it sees recv_ack, then clears them.
  task automatic deliver(input logic recv, input logic err, input logic [7:0] b, input logic rd,
                         input bit quiet);
    uart_received = recv; uart_recv_error = err; uart_rx_byte = b; rd_en = rd;
    tick(1);
    rd_en = 1'b0;
    if (!quiet) chk("ack_at_plus1", uart_recv_ack, 1);
    tick(1);
    uart_received = 1'b0; uart_recv_error = 1'b0;
    if (!quiet) chk("ack_single_cycle", uart_recv_ack, 0);
    tick(1);
  endtask

  task automatic wait_seen(input int n, input int budget, input string name);
    for (int i = 0; i < budget && seen_q.size() < n; i++) tick(1);
    chk(name, seen_q.size(), n);
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 500 && (is_tx || uart_transmit); i++) tick(1);
    tick(3);
  endtask

  typedef struct {
    logic        recv;
    logic        err;
    logic [7:0]  data;
    logic        rd;
    logic [AW:0] exp_cnt;
    logic [7:0]  exp_err;
    logic [7:0]  exp_head;
  } rx_vec_t;

  rx_vec_t    vecs[7];
  logic [7:0] rx_m[$];
  logic [7:0] exp_tx[$];
  logic       ovf_m;
  int         err_m;
  int         pushed;
  int         n0;

  initial begin
    vecs[0] = '{recv: 1, err: 0, data: 8'h3C, rd: 0, exp_cnt: 1, exp_err: 0, exp_head: 8'h3C};
    vecs[1] = '{recv: 0, err: 1, data: 8'h00, rd: 0, exp_cnt: 1, exp_err: 1, exp_head: 8'h3C};
    vecs[2] = '{recv: 1, err: 1, data: 8'h5A, rd: 0, exp_cnt: 2, exp_err: 2, exp_head: 8'h3C};
    vecs[3] = '{recv: 0, err: 0, data: 8'h00, rd: 1, exp_cnt: 1, exp_err: 2, exp_head: 8'h5A};
    vecs[4] = '{recv: 1, err: 0, data: 8'h11, rd: 1, exp_cnt: 1, exp_err: 2, exp_head: 8'h11};
    vecs[5] = '{recv: 0, err: 0, data: 8'h00, rd: 1, exp_cnt: 0, exp_err: 2, exp_head: 8'h00};
    vecs[6] = '{recv: 0, err: 0, data: 8'h00, rd: 1, exp_cnt: 0, exp_err: 2, exp_head: 8'h00};

    // Reset
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_count", tx_count, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_overflow", rx_overflow, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_transmit", uart_transmit, 0);
    chk("rst_tx_byte", uart_tx_byte, 0);
    chk("rst_recv_ack", uart_recv_ack, 0);
    tick(3);
    rst = 1'b0;
    tick(5);
    hold_busy = 1'b0;
    tick(2);

    // Two frames with a 40-cycle busy core, write-to-transmit latency of 2
    host_write(8'h55);
    chk("lat_not_yet", uart_transmit, 0);
    tick(1);
    chk("lat_transmit", uart_transmit, 1);
    chk("lat_byte", uart_tx_byte, 8'h55);
    host_write(8'hA3);
    chk("transmit_one_cycle", uart_transmit, 0);
    wait_seen(2, 300, "two_frames");
    if (seen_q.size() == 2) begin
      chk("frame0", seen_q[0], 8'h55);
      chk("frame1", seen_q[1], 8'hA3);
    end
    wait_tx_idle();
    chk("tx_byte_held", uart_tx_byte, 8'hA3);

    // 17 pushes while busy: 17th dropped, then 16 frames in order
    frame_len = 4;
    hold_busy = 1'b1;
    seen_q.delete();
    tick(1);
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'h10 + 8'(i);
      tick(1);
    end
    wr_en = 1'b0;
    chk("full_flag", tx_full, 1);
    chk("full_count", tx_count, 16);
    hold_busy = 1'b0;
    wait_seen(16, 600, "drain_16");
    tick(20);
    chk("drain_exact_16", seen_q.size(), 16);
    for (int i = 0; i < 16 && i < seen_q.size(); i++) chk("drain_order", seen_q[i], 8'h10 + 8'(i));
    chk("drained_count", tx_count, 0);
    chk("drained_full", tx_full, 0);

    // Table-driven RX vectors
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].recv || vecs[i].err) deliver(vecs[i].recv, vecs[i].err, vecs[i].data, vecs[i].rd, 0);
      else if (vecs[i].rd) host_read();
      chk("vec_rx_count", rx_count, vecs[i].exp_cnt);
      chk("vec_rx_empty", rx_empty, (vecs[i].exp_cnt == 0));
      chk("vec_err_count", err_count, vecs[i].exp_err);
      chk("vec_overflow", rx_overflow, 0);
      if (vecs[i].exp_cnt != 0) chk("vec_rd_data", rd_data, vecs[i].exp_head);
    end

    // Fill RX to 16, overflow, then pop+push in the same cycle while full
    for (int i = 0; i < 16; i++) deliver(1'b1, 1'b0, 8'(i), 1'b0, 1);
    chk("fill_count", rx_count, 16);
    chk("fill_no_ovf", rx_overflow, 0);
    deliver(1'b1, 1'b0, 8'h77, 1'b0, 0);
    chk("ovf_set", rx_overflow, 1);
    chk("ovf_count", rx_count, 16);
    chk("ovf_head", rd_data, 8'h00);
    pulse_clr();
    chk("ovf_cleared", rx_overflow, 0);
    deliver(1'b1, 1'b0, 8'h88, 1'b1, 0);
    chk("full_pp_count", rx_count, 16);
    chk("full_pp_no_ovf", rx_overflow, 0);
    for (int i = 0; i < 16; i++) begin
      chk("full_pp_order", rd_data, (i == 15) ? 8'h88 : 8'(i + 1));
      host_read();
    end
    chk("full_pp_empty", rx_empty, 1);

    // Error counter saturation and clear
    pulse_clr();
    for (int i = 0; i < 300; i++) deliver(1'b0, 1'b1, 8'h00, 1'b0, 1);
    chk("err_saturate", err_count, 255);
    pulse_clr();
    chk("err_cleared", err_count, 0);
    chk("clr_ovf_zero", rx_overflow, 0);
    for (int i = 0; i < 3; i++) deliver(1'b0, 1'b1, 8'h00, 1'b0, 1);
    chk("err_three", err_count, 3);
    stat_clr = 1'b1; uart_recv_error = 1'b1;
    tick(1);
    stat_clr = 1'b0;
    tick(1);
    uart_recv_error = 1'b0;
    tick(1);
    chk("clr_vs_event", err_count, 1);
    pulse_clr();

    // Randomized phase against the queue model
    frame_len = 3;
    seen_q.delete();
    exp_tx.delete();
    rx_m.delete();
    ovf_m = 1'b0;
    err_m = 0;
    pushed = 0;
    for (int s = 0; s < 300; s++) begin
      int op;
      op = int'($urandom_range(0, 4));
      if (op == 0) begin
        if (pushed - seen_q.size() < 12) begin
          logic [7:0] b;
          b = 8'($urandom);
          host_write(b);
          exp_tx.push_back(b);
          pushed++;
        end else tick(1);
      end else if (op == 1) begin
        if (rx_m.size() > 0) chk("rnd_rd_data", rd_data, rx_m[0]);
        host_read();
        if (rx_m.size() > 0) void'(rx_m.pop_front());
      end else if (op == 2 || op == 3) begin
        int k;
        logic [7:0] b;
        k = int'($urandom_range(0, 2));
        b = 8'($urandom);
        deliver(k != 1, k != 0, b, 1'b0, 1);
        if (k != 1) begin
          if (rx_m.size() < DEPTH) rx_m.push_back(b);
          else ovf_m = 1'b1;
        end
        if (k != 0 && err_m < 255) err_m++;
      end else begin
        if ($urandom_range(0, 7) == 0) begin
          pulse_clr();
          ovf_m = 1'b0;
          err_m = 0;
        end else tick(1);
      end
      chk("rnd_rx_count", rx_count, rx_m.size());
      chk("rnd_overflow", rx_overflow, ovf_m);
      chk("rnd_err_count", err_count, err_m);
    end
    wait_seen(pushed, 2000, "rnd_tx_frames");
    for (int i = 0; i < pushed && i < seen_q.size(); i++) chk("rnd_tx_byte", seen_q[i], exp_tx[i]);
    wait_tx_idle();

    // Asynchronous reset while waiting for the core to finish a frame
    frame_len = 40;
    deliver(1'b1, 1'b1, 8'h42, 1'b0, 1);
    host_write(8'hC1);
    for (int i = 0; i < 20 && !(busy_cnt != 0); i++) tick(1);
    tick(2);
    for (int i = 0; i < 5; i++) host_write(8'hD0 + 8'(i));
    chk("pre_rst_count", tx_count, 5);
    chk("pre_rst_rx", rx_empty, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_tx_count", tx_count, 0);
    chk("arst_transmit", uart_transmit, 0);
    chk("arst_tx_byte", uart_tx_byte, 0);
    chk("arst_rx_empty", rx_empty, 1);
    chk("arst_err", err_count, 0);
    chk("arst_ack", uart_recv_ack, 0);
    tick(2);
    rst = 1'b0;
    n0 = seen_q.size();
    tick(60);
    chk("no_tx_after_reset", seen_q.size(), n0);
    host_write(8'hE7);
    wait_seen(n0 + 1, 50, "tx_after_new_write");
    if (seen_q.size() == n0 + 1) chk("new_write_byte", seen_q[n0], 8'hE7);
    wait_tx_idle();

    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
